// File: rtl/clk_en_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package clk_en_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } lock_state_e;

  // Rounded increment that gives f_out_hz enables from an f_sys_hz clock.
  function automatic longint unsigned inc_for(input longint unsigned f_sys_hz,
                                              input longint unsigned f_out_hz,
                                              input int unsigned     acc_w);
    return ((f_out_hz << acc_w) + (f_sys_hz >> 1)) / f_sys_hz;
  endfunction

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator enable channel with a shadow increment that is
// committed only on a carry (or while idle) so the output period never glitches.
module nco_channel
  import clk_en_pkg::*;
#(
  parameter int               ACC_W    = 24,
  parameter logic [ACC_W-1:0] INIT_INC = ACC_W'(1) << (ACC_W - 2)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             run_en,
  input  logic             inc_wr,
  input  logic [ACC_W-1:0] inc_data,
  output logic             ce_out
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] act_q, act_d;
  logic [ACC_W-1:0] shd_q, shd_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
  logic             commit;

  // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, act_q};
    acc_d  = '0;
    ce_d   = 1'b0;
    commit = 1'b1;
    if (run_en) begin
      acc_d  = sum[ACC_W-1:0];
      ce_d   = sum[ACC_W];
      commit = sum[ACC_W] || (act_q == '0);
    end
    // Taking shd_d rather than shd_q lets a write on the commit cycle bypass the shadow.
    shd_d = inc_wr ? inc_data : shd_q;
    act_d = commit ? shd_d : act_q;
  end

  // NOTE: non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_q <= '0;
      act_q <= INIT_INC;
      shd_q <= INIT_INC;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      act_q <= act_d;
      shd_q <= shd_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_out = ce_q;

endmodule

// File: rtl/clk_en_nco.sv
// N-channel fractional clock-enable generator; enables and the downstream reset
// are released only after the PLL lock has been stable for LOCK_CYC cycles.
module clk_en_nco
  import clk_en_pkg::*;
#(
  parameter int               CHANNELS = 2,
  parameter int               ACC_W    = 24,
  parameter int               LOCK_CYC = 1024,
  parameter logic [ACC_W-1:0] INIT_INC = ACC_W'(1) << (ACC_W - 2)
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                pll_lock,
  input  logic [CHANNELS-1:0] inc_wr,
  input  logic [ACC_W-1:0]    inc_data,
  output logic [CHANNELS-1:0] ce_out,
  output logic                run_rst_n,
  output logic                locked
);

  localparam int               CNT_W    = $clog2(LOCK_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYC - 1);

  logic             sync1_q, lock_s_q;
  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             run_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      HOLD: if (lock_s_q) state_d = WAIT;
      WAIT: begin
        if (!lock_s_q) begin
          state_d = HOLD;
        end else begin
          // The HOLD->WAIT cycle is the first of the LOCK_CYC stable cycles.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_LAST) state_d = RUN;
        end
      end
      RUN:     if (!lock_s_q) state_d = HOLD;
      default: state_d = HOLD;
    endcase
    run_d  = (state_d == RUN);
    // Accumulate only while staying in RUN, so enables drop on the HOLD cycle itself.
    run_en = (state_q == RUN) && run_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
      state_q  <= HOLD;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  assign run_rst_n = run_q;
  assign locked    = run_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    nco_channel #(
      .ACC_W   (ACC_W),
      .INIT_INC(INIT_INC)
    ) u_ch (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .run_en   (run_en),
      .inc_wr   (inc_wr[i]),
      .inc_data (inc_data),
      .ce_out   (ce_out[i])
    );
  end

endmodule

// File: tb/tb_clk_en_nco.sv
// Bench for clk_en_nco: rate table, hand-timed lock/update corners and random
// traffic, all compared against a cycle-level arithmetic reference model.
module tb_clk_en_nco;

  localparam int CH   = 2;
  localparam int W    = 8;
  localparam int LC   = 16;
  localparam int MOD  = 1 << W;
  localparam int INIT = MOD / 4;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          pll_lock  = 1'b0;
  logic [CH-1:0] inc_wr    = '0;
  logic [W-1:0]  inc_data  = '0;
  logic [CH-1:0] ce_out;
  logic          run_rst_n;
  logic          locked;

  clk_en_nco #(
    .CHANNELS(CH),
    .ACC_W   (W),
    .LOCK_CYC(LC)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pll_lock (pll_lock),
    .inc_wr   (inc_wr),
    .inc_data (inc_data),
    .ce_out   (ce_out),
    .run_rst_n(run_rst_n),
    .locked   (locked)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int ch;
    int inc;
    int cycles;
    int exp_cnt;
  } rate_vec_t;

  // Reference model: lock is "run" once the two-cycle-delayed lock has been
  // high for LC consecutive cycles; channels are plain modular sums.
  bit lock_dly[2];
  int lock_run;
  bit m_run;
  int m_acc[CH];
  int m_act[CH];
  int m_shd[CH];
  bit m_ce[CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    lock_dly[0] = 1'b0;
    lock_dly[1] = 1'b0;
    lock_run    = 0;
    m_run       = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0;
      m_act[c] = INIT;
      m_shd[c] = INIT;
      m_ce[c]  = 1'b0;
    end
  endtask

  task automatic model_step();
    bit lock_s;
    bit run_next;
    bit en;
    lock_s   = lock_dly[1];
    lock_run = lock_s ? ((lock_run < LC) ? lock_run + 1 : LC) : 0;
    run_next = (lock_run >= LC);
    en       = m_run && run_next;
    for (int c = 0; c < CH; c++) begin
      bit commit;
      int sum;
      commit = 1'b1;
      if (en) begin
        sum      = m_acc[c] + m_act[c];
        m_ce[c]  = (sum >= MOD);
        commit   = (sum >= MOD) || (m_act[c] == 0);
        m_acc[c] = sum % MOD;
      end else begin
        m_acc[c] = 0;
        m_ce[c]  = 1'b0;
      end
      if (inc_wr[c]) m_shd[c] = int'(inc_data);
      if (commit) m_act[c] = m_shd[c];
    end
    lock_dly[1] = lock_dly[0];
    lock_dly[0] = pll_lock;
    m_run       = run_next;
  endtask

  task automatic tick();
    logic [CH-1:0] e;
    @(posedge sys_clk);
    model_step();
    #1;
    for (int c = 0; c < CH; c++) e[c] = m_ce[c];
    check("model_ce_out", ce_out, e);
    check("model_run_rst_n", run_rst_n, m_run);
    check("model_locked", locked, m_run);
  endtask

  task automatic write_inc(input logic [CH-1:0] mask, input int v);
    inc_wr   = mask;
    inc_data = W'(v);
    tick();
    inc_wr   = '0;
  endtask

  task automatic wait_commit(input int ch, input int v);
    for (int i = 0; i < 600 && m_act[ch] != v; i++) tick();
    if (m_act[ch] != v) begin
      checks++;
      failures++;
      $display("FAIL commit_wait ch%0d actual=%0d required=%0d", ch, m_act[ch], v);
    end
  endtask

  task automatic wait_run(input logic val, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (run_rst_n === val) begin
        n = i;
        break;
      end
    end
  endtask

  // Call right after the tick on which run_rst_n rose (RUN cycle 1); both channels at 64.
  task automatic check_first_ce_pattern(input string tag);
    logic [CH-1:0] e;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      e = (c >= 5 && (c % 4) == 1) ? {CH{1'b1}} : '0;
      check($sformatf("%s_ce_run_cycle%0d", tag, c), ce_out, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rate_vec_t vecs[8];
    int        n;
    int        cnt;
    int        low_left;
    bit        found;
    int        ce_exp[20];

    vecs[0] = '{0, 64,  256,  64};
    vecs[1] = '{0, 128, 256,  128};
    vecs[2] = '{0, 3,   1024, 12};
    vecs[3] = '{1, 1,   512,  2};
    vecs[4] = '{1, 200, 256,  200};
    vecs[5] = '{0, 0,   1000, 0};
    vecs[6] = '{0, 255, 256,  255};
    vecs[7] = '{1, 255, 512,  510};
    ce_exp  = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1,
                0, 1, 0, 0, 0, 1, 0, 0, 0, 1};

    // Reset state
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_ce_out", ce_out, 0);
    check("reset_run_rst_n", run_rst_n, 0);
    check("reset_locked", locked, 0);
    #1 sys_rst_n = 1'b1;
    repeat (4) tick();

    // Lock debounce: RUN exactly 2 + LC cycles after the lock edge
    pll_lock = 1'b1;
    wait_run(1'b1, 200, n);
    check("debounce_cycles", n, 2 + LC);
    check("debounce_locked", locked, 1);
    check_first_ce_pattern("first_run");

    // Rate table
    foreach (vecs[v]) begin
      write_inc(CH'(1 << vecs[v].ch), vecs[v].inc);
      wait_commit(vecs[v].ch, vecs[v].inc);
      cnt = 0;
      repeat (vecs[v].cycles) begin
        tick();
        cnt += int'(ce_out[vecs[v].ch]);
      end
      check($sformatf("rate_ch%0d_inc%0d_over%0d", vecs[v].ch, vecs[v].inc, vecs[v].cycles),
            cnt, vecs[v].exp_cnt);
    end

    // Glitch-free update: 64 -> 128 mid-period, then 128 -> 64 on a carry cycle
    write_inc(CH'(1), 64);
    wait_commit(0, 64);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      found = ce_out[0];
    end
    check("glitch_sync_pulse", found, 1);
    for (int k = 1; k <= 20; k++) begin
      if (k == 2 || k == 12) begin
        inc_wr   = CH'(1);
        inc_data = (k == 2) ? W'(128) : W'(64);
      end
      tick();
      inc_wr = '0;
      check($sformatf("glitch_ce_T+%0d", k), ce_out[0], ce_exp[k-1]);
    end

    // Lock loss in RUN, then re-lock with accumulators restarted from 0
    write_inc({CH{1'b1}}, 64);
    wait_commit(0, 64);
    wait_commit(1, 64);
    pll_lock = 1'b0;
    wait_run(1'b0, 10, n);
    check("lock_loss_latency", n, 3);
    check("lock_loss_locked", locked, 0);
    check("lock_loss_ce_out", ce_out, 0);
    repeat (4) tick();
    pll_lock = 1'b1;
    wait_run(1'b1, 200, n);
    check("relock_cycles", n, 2 + LC);
    check_first_ce_pattern("relock");

    // One-cycle dropout at WAIT cycle 10 restarts the debounce count
    pll_lock = 1'b0;
    wait_run(1'b0, 10, n);
    check("dropout_setup_loss", n, 3);
    repeat (4) tick();
    pll_lock = 1'b1;
    repeat (13) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_run(1'b1, 200, n);
    check("dropout_restart_cycles", n, 2 + LC);

    // Random writes and lock glitches against the model
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      inc_wr   = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
      inc_data = W'($urandom);
      if (low_left == 0 && $urandom_range(0, 399) == 0) low_left = $urandom_range(1, 4);
      pll_lock = (low_left == 0);
      if (low_left > 0) low_left--;
      tick();
    end
    inc_wr   = '0;
    pll_lock = 1'b1;
    wait_run(1'b1, 200, n);
    check("random_phase_run_reached", run_rst_n, 1);
    repeat (10) tick();

    // Asynchronous reset mid-RUN
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_ce_out", ce_out, 0);
    check("async_rst_run_rst_n", run_rst_n, 0);
    check("async_rst_locked", locked, 0);
    model_reset();
    #4 sys_rst_n = 1'b1;
    wait_run(1'b1, 200, n);
    check("after_reset_cycles", n, 2 + LC);
    check_first_ce_pattern("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
